// File: rtl/fetch_arb_pkg.sv
// Shared defaults and round-robin search helper for the fetch memory arbiter.
package fetch_arb_pkg;

  localparam int NREQ_DEF = 2;
  localparam int AW_DEF   = 5;
  localparam int DW_DEF   = 32;
  localparam int MAX_NREQ = 4;
  localparam int IDX_W    = 2;   // enough to index MAX_NREQ requesters

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_res_t;

  // First candidate after 'last' (wrapping modulo n); found=0 if none.
  function automatic rr_res_t rr_next(input int n,
                                      input logic [IDX_W-1:0] last,
                                      input logic [MAX_NREQ-1:0] cand);
    rr_res_t r;
    int      j;
    r = '0;
    for (int k = 1; k <= MAX_NREQ; k++) begin
      if (k <= n) begin
        j = (int'(last) + k) % n;
        if (!r.found && cand[j]) begin
          r.found = 1'b1;
          r.idx   = IDX_W'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_arbiter_if.sv
// Requester-side and memory-side bus of the fetch arbiter.
// master = requesters + memory model, slave = the arbiter itself.
interface fetch_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               mem_we;
  logic [AW-1:0]      mem_a1;
  logic [DW-1:0]      mem_data_in;
  logic               mem_re;
  logic [AW-1:0]      mem_a2;
  logic [DW-1:0]      mem_data_out;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_data_out,
    input  req_ready, rsp_valid, rsp_data, mem_we, mem_a1, mem_data_in, mem_re, mem_a2
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_data_out,
    output req_ready, rsp_valid, rsp_data, mem_we, mem_a1, mem_data_in, mem_re, mem_a2
  );
endinterface

// File: rtl/rr_arbiter.sv
// Single-port round-robin arbiter: one-hot grant, pointer moves only on a grant.
module rr_arbiter
  import fetch_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  output logic [NREQ-1:0]  gnt,
  output logic             gnt_vld,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0]    last;
  logic [MAX_NREQ-1:0] req_w;
  rr_res_t             res;

  // Search from last+1 and expand the winner into a one-hot grant.
  always_comb begin
    req_w            = '0;
    req_w[NREQ-1:0]  = req;
    res              = rr_next(NREQ, last, req_w);
    gnt_vld          = res.found;
    gnt_idx          = res.idx;
    for (int i = 0; i < NREQ; i++)
      gnt[i] = res.found && (res.idx == IDX_W'(i));
  end

  // Reset to NREQ-1 so requester 0 is first in line.
  always_ff @(posedge clk) begin
    if (!rst_n)         last <= IDX_W'(NREQ - 1);
    else if (res.found) last <= res.idx;
  end

endmodule

// File: rtl/fetch_arbiter.sv
// Shares the fetch memory between NREQ requesters. Read and write ports are
// arbitrated independently; read data returns one cycle after acceptance.
module fetch_arbiter
  import fetch_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_arbiter_if.slave bus
);

  logic [NREQ-1:0]  rd_cand, wr_cand;
  logic [NREQ-1:0]  rd_gnt, wr_gnt;
  logic             rd_vld, wr_vld;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic             rsp_pend;
  logic [IDX_W-1:0] rsp_id;

  assign rd_cand = bus.req_valid & ~bus.req_we;
  assign wr_cand = bus.req_valid &  bus.req_we;

  rr_arbiter #(.NREQ(NREQ)) u_rd_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (rd_cand),
    .gnt     (rd_gnt),
    .gnt_vld (rd_vld),
    .gnt_idx (rd_idx)
  );

  rr_arbiter #(.NREQ(NREQ)) u_wr_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (wr_cand),
    .gnt     (wr_gnt),
    .gnt_vld (wr_vld),
    .gnt_idx (wr_idx)
  );

  // Steer the granted requester onto each memory port; idle ports drive zeros.
  // Everything is gated by rst_n so nothing reaches memory during reset.
  always_comb begin
    bus.mem_we      = 1'b0;
    bus.mem_a1      = '0;
    bus.mem_data_in = '0;
    bus.mem_re      = 1'b0;
    bus.mem_a2      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (rst_n && wr_gnt[i]) begin
        bus.mem_we      = 1'b1;
        bus.mem_a1      = bus.req_addr[i*AW +: AW];
        bus.mem_data_in = bus.req_wdata[i*DW +: DW];
      end
      if (rst_n && rd_gnt[i]) begin
        bus.mem_re = 1'b1;
        bus.mem_a2 = bus.req_addr[i*AW +: AW];
      end
    end
  end

  assign bus.req_ready = (rd_gnt | wr_gnt) & {NREQ{rst_n}};

  // Remember who issued the read so the registered memory data can be routed back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_pend <= 1'b0;
      rsp_id   <= '0;
    end else begin
      rsp_pend <= rd_vld;
      if (rd_vld) rsp_id <= rd_idx;
    end
  end

  // One-hot response strobe, forced low while reset is asserted.
  always_comb begin
    for (int i = 0; i < NREQ; i++)
      bus.rsp_valid[i] = rst_n && rsp_pend && (rsp_id == IDX_W'(i));
  end

  assign bus.rsp_data = bus.mem_data_out;

endmodule

// File: tb/tb_fetch_arbiter.sv
// Directed bench for fetch_arbiter with a behavioural 32x32 memory and a
// response scoreboard.
module tb_fetch_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 5;
  localparam int DW   = 32;

  localparam logic [31:0] W1   = 32'h40C80000;
  localparam logic [31:0] W2   = 32'hBFC00000;
  localparam logic [31:0] ONE  = 32'h3F800000;
  localparam logic [31:0] DA   = 32'h11111111;
  localparam logic [31:0] DB   = 32'h22222222;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;

  logic clk, rst_n;
  fetch_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus();

  fetch_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int     n_cmp = 0;
  int     n_bad = 0;
  int     wr4_cnt = 0;
  exp_t   sb[$];
  logic [31:0] mem [32];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Memory model: write at the edge, registered read returns pre-edge contents.
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[1] = W1;
    mem[2] = W2;
  end

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_a1] <= bus.mem_data_in;
    if (bus.mem_re) bus.mem_data_out <= mem[bus.mem_a2];
    if (bus.mem_we && bus.mem_a1 == 5'd4 && bus.mem_data_in == DB) wr4_cnt <= wr4_cnt + 1;
  end

  // Response monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.rsp_valid != '0) begin
      if (sb.size() == 0) chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
      else begin
        e = sb.pop_front();
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(1) << e.id);
        chk("rsp_data", bus.rsp_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i]          = v;
    bus.req_we[i]             = we;
    bus.req_addr[i*AW +: AW]  = a;
    bus.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    idle();
    cyc();

    // Reset gating: a read request during reset is neither accepted nor issued.
    set_req(0, 1'b1, 1'b0, 5'd1, '0);
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_mem_re", 32'(bus.mem_re), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    cyc();
    rst_n = 1'b1;
    idle();
    #1;
    chk("idle_a2", 32'(bus.mem_a2), 32'd0);
    chk("idle_mem_re", 32'(bus.mem_re), 32'd0);
    cyc();

    // Single read.
    set_req(0, 1'b1, 1'b0, 5'd1, '0);
    #1;
    chk("rd1_ready", 32'(bus.req_ready), 32'd1);
    chk("rd1_a2", 32'(bus.mem_a2), 32'd1);
    e.id = 0; e.data = W1; sb.push_back(e);
    cyc();
    idle();
    #1;
    chk("rd1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("rd1_rsp_data", bus.rsp_data, W1);
    cyc();

    // Read contention: strict alternation starting at requester 0.
    do_reset();
    set_req(0, 1'b1, 1'b0, 5'd1, '0);
    set_req(1, 1'b1, 1'b0, 5'd2, '0);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("rr_ready", 32'(bus.req_ready), 32'(1) << (c % 2));
      e.id = c % 2; e.data = (c % 2) ? W2 : W1; sb.push_back(e);
      cyc();
    end
    idle();
    cyc();

    // Write and read of the same address in one cycle: read sees old data.
    set_req(0, 1'b1, 1'b1, 5'd7, ONE);
    set_req(1, 1'b1, 1'b0, 5'd7, '0);
    #1;
    chk("par_ready", 32'(bus.req_ready), 32'd3);
    chk("par_we_re", {30'd0, bus.mem_we, bus.mem_re}, 32'd3);
    chk("par_din", bus.mem_data_in, ONE);
    e.id = 1; e.data = 32'd0; sb.push_back(e);
    cyc();
    set_req(0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("par2_ready", 32'(bus.req_ready), 32'd2);
    e.id = 1; e.data = ONE; sb.push_back(e);
    cyc();
    idle();
    cyc();

    // Read accepted, then reset: pending response is suppressed.
    set_req(0, 1'b1, 1'b0, 5'd1, '0);
    #1;
    chk("rm_ready", 32'(bus.req_ready), 32'd1);
    cyc();
    rst_n = 1'b0;
    idle();
    #1;
    chk("rm_rsp_gated", 32'(bus.rsp_valid), 32'd0);
    // Read presented while rst_n is sampled low.
    set_req(0, 1'b1, 1'b0, 5'd1, '0);
    cyc();
    rst_n = 1'b1;
    idle();
    #1;
    chk("rm_rsp_dropped", 32'(bus.rsp_valid), 32'd0);
    cyc();

    // After reset requester 0 wins read contention first.
    set_req(0, 1'b1, 1'b0, 5'd1, '0);
    set_req(1, 1'b1, 1'b0, 5'd2, '0);
    #1;
    chk("post_rst_rd_ready", 32'(bus.req_ready), 32'd1);
    e.id = 0; e.data = W1; sb.push_back(e);
    cyc();
    set_req(0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("post_rst_rd2_ready", 32'(bus.req_ready), 32'd2);
    e.id = 1; e.data = W2; sb.push_back(e);
    cyc();
    idle();

    // Write contention: req1 loses, holds, then is granted exactly once.
    set_req(0, 1'b1, 1'b1, 5'd3, DA);
    set_req(1, 1'b1, 1'b1, 5'd4, DB);
    #1;
    chk("hold_ready0", 32'(bus.req_ready), 32'd1);
    chk("hold_a1_0", 32'(bus.mem_a1), 32'd3);
    cyc();
    set_req(0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("hold_ready1", 32'(bus.req_ready), 32'd2);
    chk("hold_a1_1", 32'(bus.mem_a1), 32'd4);
    chk("hold_din", bus.mem_data_in, DB);
    cyc();
    idle();
    #1;
    chk("hold_idle_we", 32'(bus.mem_we), 32'd0);
    chk("hold_idle_din", bus.mem_data_in, 32'd0);
    cyc();
    chk("hold_pulses", 32'(wr4_cnt), 32'd1);

    // Read back both posted writes.
    set_req(1, 1'b1, 1'b0, 5'd4, '0);
    e.id = 1; e.data = DB; sb.push_back(e);
    cyc();
    idle();
    set_req(0, 1'b1, 1'b0, 5'd3, '0);
    e.id = 0; e.data = DA; sb.push_back(e);
    cyc();
    idle();
    cyc();
    cyc();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
